// File: rtl/mbe_dot_pkg.sv
// mbe_dot_pkg: shared state encoding, default sizes and accumulator width helper for the dot-product accumulator
package mbe_dot_pkg;
  typedef enum logic [1:0] {INIT, ACCUM, SEND} state_t;
  localparam int DEF_P_WIDTH = 64;
  localparam int DEF_N_TERMS = 8;
  function automatic int acc_width(input int p_width, input int n_terms);
    return p_width + $clog2(n_terms) + 1;
  endfunction
endpackage

// File: rtl/mbe_dot_accum_fsm.sv
// mbe_dot_accum_fsm: handshake control and term counter; ports clk/rst, i_valid/i_last/i_out_ready in, o_in_ready/o_out_valid registered, o_accept/o_final strobes, o_cnt terms taken so far
module mbe_dot_accum_fsm import mbe_dot_pkg::*; #(
  parameter int N_TERMS = DEF_N_TERMS,
  parameter int CNT_WIDTH = $clog2(N_TERMS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic                 i_last,
  input  logic                 i_out_ready,
  output logic                 o_in_ready,
  output logic                 o_out_valid,
  output logic                 o_accept,
  output logic                 o_final,
  output logic [CNT_WIDTH-1:0] o_cnt
);
  state_t r_state, w_state;
  logic r_in_ready, w_in_ready, r_out_valid, w_out_valid;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt;
  assign o_in_ready = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_cnt = r_cnt;
  assign o_accept = i_valid && r_in_ready;
  assign o_final = o_accept && (i_last || r_cnt == CNT_WIDTH'(N_TERMS - 1));
  always_comb begin
    w_state = r_state;
    w_in_ready = r_in_ready;
    w_out_valid = r_out_valid;
    w_cnt = r_cnt;
    case (r_state)
      INIT: begin
        w_state = ACCUM;
        w_in_ready = 1'b1;
      end
      ACCUM: begin
        if (o_final) begin
          w_state = SEND;
          w_in_ready = 1'b0;
          w_out_valid = 1'b1;
          w_cnt = '0;
        end else if (o_accept) begin
          w_cnt = r_cnt + CNT_WIDTH'(1);
        end
      end
      SEND: begin
        if (i_out_ready) begin
          w_state = ACCUM;
          w_in_ready = 1'b1;
          w_out_valid = 1'b0;
        end
      end
      default: w_state = INIT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= INIT;
      r_in_ready <= 1'b0;
      r_out_valid <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_state <= w_state;
      r_in_ready <= w_in_ready;
      r_out_valid <= w_out_valid;
      r_cnt <= w_cnt;
    end
  end
endmodule

// File: rtl/mbe_dot_accum.sv
// mbe_dot_accum: sums up to N_TERMS signed products into one result; ports clk/rst, in_valid/in_ready/in_data/in_last product stream, out_valid/out_ready/out_data/out_count result stream
module mbe_dot_accum import mbe_dot_pkg::*; #(
  parameter int P_WIDTH = DEF_P_WIDTH,
  parameter int N_TERMS = DEF_N_TERMS,
  localparam int ACC_WIDTH = acc_width(P_WIDTH, N_TERMS),
  localparam int CNT_WIDTH = $clog2(N_TERMS + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [P_WIDTH-1:0]   in_data,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]        out_count
);
  logic w_accept, w_final;
  logic [CNT_WIDTH-1:0] w_cnt;
  logic signed [ACC_WIDTH-1:0] r_acc, w_sum;
  assign w_sum = r_acc + {{(ACC_WIDTH-P_WIDTH){in_data[P_WIDTH-1]}}, in_data};
  mbe_dot_accum_fsm #(.N_TERMS(N_TERMS), .CNT_WIDTH(CNT_WIDTH)) u_fsm (
    .clk(clk),
    .rst(rst),
    .i_valid(in_valid),
    .i_last(in_last),
    .i_out_ready(out_ready),
    .o_in_ready(in_ready),
    .o_out_valid(out_valid),
    .o_accept(w_accept),
    .o_final(w_final),
    .o_cnt(w_cnt)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      out_data <= '0;
      out_count <= '0;
    end else if (w_final) begin
      r_acc <= '0;
      out_data <= w_sum;
      out_count <= w_cnt + CNT_WIDTH'(1);
    end else if (w_accept) begin
      r_acc <= w_sum;
    end
  end
endmodule

// File: tb/tb_mbe_dot_accum.sv
// tb_mbe_dot_accum: self-checking bench for the dot-product accumulator (N_TERMS=4 and N_TERMS=1 builds)
module tb_mbe_dot_accum;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_last = 0, out_ready = 0, in_ready, out_valid;
  logic signed [63:0] in_data = 0;
  logic signed [66:0] out_data;
  logic [2:0] out_count;
  logic in_valid1 = 0, in_last1 = 0, out_ready1 = 1, in_ready1, out_valid1;
  logic signed [63:0] in_data1 = 0;
  logic signed [64:0] out_data1;
  logic [0:0] out_count1;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  mbe_dot_accum #(.P_WIDTH(64), .N_TERMS(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
  );
  mbe_dot_accum #(.P_WIDTH(64), .N_TERMS(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1), .in_last(in_last1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1), .out_count(out_count1)
  );
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
  task automatic drive_beat(input logic signed [63:0] d, input logic l, input bit b2b);
    int n = 0;
    in_valid = 1; in_data = d; in_last = l;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (in_ready !== 1'b1 || (b2b && n != 0)) begin failures++; $display("FAIL accept_wait: in_ready=%b after %0d wait cycles, required 1 after %0s", in_ready, n, b2b ? "0" : "<20"); end
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
  endtask
  task automatic run_group(input logic signed [63:0] v[$], input bit lst, input bit b2b, output logic signed [66:0] es, output int ec);
    es = 0; ec = v.size();
    foreach (v[i]) begin
      es = es + v[i];
      drive_beat(v[i], lst && i == v.size() - 1, b2b);
    end
  endtask
  task automatic collect(input logic signed [66:0] es, input int ec, input int stall);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL result_valid: got %b, required 1", out_valid); end
    checks++; if (out_data !== es) begin failures++; $display("FAIL result_data: got %0d, required %0d", out_data, es); end
    checks++; if (out_count !== 3'(ec)) begin failures++; $display("FAIL result_count: got %0d, required %0d", out_count, ec); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL ready_in_send: got %b, required 0", in_ready); end
    out_ready = 0;
    repeat (stall) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== es || out_count !== 3'(ec) || in_ready !== 1'b0) begin
        failures++; $display("FAIL hold: valid=%b data=%0d count=%0d in_ready=%b, required 1/%0d/%0d/0", out_valid, out_data, out_count, in_ready, es, ec);
      end
    end
    out_ready = 1; @(posedge clk); #1; out_ready = 0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL handshake: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready); end
  endtask
  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL reset_ctrl: in_ready=%b out_valid=%b, required 0/0", in_ready, out_valid); end
    checks++; if (out_data !== 67'sd0 || out_count !== 3'd0) begin failures++; $display("FAIL reset_data: data=%0d count=%0d, required 0/0", out_data, out_count); end
    checks++; if (in_ready1 !== 1'b0 || out_valid1 !== 1'b0) begin failures++; $display("FAIL reset_n1: in_ready=%b out_valid=%b, required 0/0", in_ready1, out_valid1); end
    rst = 0;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL init_idle: in_ready=%b, required 0", in_ready); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL init_ready: in_ready=%b, required 1", in_ready); end
  endtask
  task automatic test_full_group();
    logic signed [63:0] q[$];
    logic signed [66:0] es;
    int ec;
    q = '{3, 5, -2, 10};
    run_group(q, 0, 1, es, ec);
    collect(es, ec, 0);
  endtask
  task automatic test_early_last();
    logic signed [63:0] q[$];
    logic signed [66:0] es;
    int ec;
    q = '{7, -9};
    run_group(q, 1, 1, es, ec);
    collect(es, ec, 0);
    q = '{1, 1, 1, 1};
    run_group(q, 0, 1, es, ec);
    collect(es, ec, 0);
  endtask
  task automatic test_backpressure();
    logic signed [63:0] q[$];
    logic signed [66:0] es;
    int ec;
    q = '{3, 5, -2, 10};
    run_group(q, 0, 1, es, ec);
    in_valid = 1; in_data = 99; in_last = 1;
    collect(es, ec, 5);
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
    collect(67'sd99, 1, 0);
  endtask
  task automatic test_extremes();
    logic signed [63:0] q[$];
    logic signed [66:0] es;
    int ec;
    q = '{64'sh8000_0000_0000_0000, 64'sh8000_0000_0000_0000, 64'sh8000_0000_0000_0000, 64'sh8000_0000_0000_0000};
    run_group(q, 0, 1, es, ec);
    collect(es, ec, 0);
    q = '{64'sh7fff_ffff_ffff_ffff, 64'sh7fff_ffff_ffff_ffff, 64'sh7fff_ffff_ffff_ffff, 64'sh7fff_ffff_ffff_ffff};
    run_group(q, 1, 1, es, ec);
    collect(es, ec, 0);
  endtask
  task automatic test_reset_mid();
    logic signed [63:0] q[$];
    logic signed [66:0] es;
    int ec;
    drive_beat(5, 0, 1);
    drive_beat(6, 0, 1);
    rst = 1; @(posedge clk); #1; rst = 0;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL mid_reset: in_ready=%b out_valid=%b, required 0/0", in_ready, out_valid); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_init: in_ready=%b, required 1", in_ready); end
    q = '{1, 2, 3, 4};
    run_group(q, 0, 1, es, ec);
    collect(es, ec, 0);
  endtask
  task automatic test_reset_send();
    logic signed [63:0] q[$];
    logic signed [66:0] es;
    int ec;
    q = '{1, 2, 3};
    run_group(q, 1, 1, es, ec);
    checks++; if (out_valid !== 1'b1 || out_data !== es) begin failures++; $display("FAIL send_before_reset: valid=%b data=%0d, required 1/%0d", out_valid, out_data, es); end
    rst = 1; @(posedge clk); #1; rst = 0;
    checks++; if (out_valid !== 1'b0 || out_data !== 67'sd0) begin failures++; $display("FAIL send_reset: valid=%b data=%0d, required 0/0", out_valid, out_data); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL send_reset_init: in_ready=%b, required 1", in_ready); end
  endtask
  task automatic test_n1();
    logic signed [63:0] v;
    logic signed [64:0] e1;
    for (int k = 0; k < 6; k++) begin
      int n = 0;
      v = (k == 0) ? -64'sd1 : {$urandom, $urandom};
      e1 = v;
      in_valid1 = 1; in_data1 = v;
      while (!in_ready1 && n < 20) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      in_valid1 = 0;
      checks++; if (out_valid1 !== 1'b1 || out_data1 !== e1 || out_count1 !== 1'b1) begin failures++; $display("FAIL n1_result: valid=%b data=%0d count=%0d, required 1/%0d/1", out_valid1, out_data1, out_count1, e1); end
      @(posedge clk); #1;
      checks++; if (out_valid1 !== 1'b0) begin failures++; $display("FAIL n1_handshake: valid=%b, required 0", out_valid1); end
    end
  endtask
  task automatic test_random();
    logic signed [63:0] v;
    logic signed [66:0] es;
    for (int g = 0; g < 25; g++) begin
      int len = $urandom_range(1, 4);
      bit lst = (len < 4) ? 1'b1 : 1'($urandom_range(0, 1));
      es = 0;
      for (int i = 0; i < len; i++) begin
        int sel = $urandom_range(0, 3);
        v = (sel == 0) ? 64'sh8000_0000_0000_0000 : (sel == 1) ? 64'sh7fff_ffff_ffff_ffff : {$urandom, $urandom};
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
          checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL idle: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready); end
        end
        es = es + v;
        drive_beat(v, lst && i == len - 1, 0);
      end
      collect(es, len, $urandom_range(0, 3));
    end
  endtask
  initial begin
    test_reset();
    test_full_group();
    test_early_last();
    test_backpressure();
    test_extremes();
    test_reset_mid();
    test_reset_send();
    test_n1();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
